// File: rtl/rx_seg_pkg.sv
// Shared types for the RX segment router: header FSM states, routing tag layout
// and a width helper.
package rx_seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    typedef struct packed {
        logic       route;
        logic [7:0] ch;
    } tag_t;

    localparam tag_t TAG_DROP = '{route: 1'b0, ch: 8'd0};

    localparam int CNT_W = 12;
    localparam int SEG_W = 32;

    // Ceiling log2, never below 1 so it can size a select for a single channel.
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) width++;
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/rx_byte_delay.sv
// Fixed-depth shift line carrying {valid, sof, byte}; only the valid bits are reset
// so a flushed line emits nothing.
module rx_byte_delay #(
    parameter int DEPTH = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vld,
    input  logic       sof,
    input  logic [7:0] data,
    output logic       vld_dly,
    output logic       sof_dly,
    output logic [7:0] data_dly
);

    logic [DEPTH-1:0] vld_line;
    logic [DEPTH-1:0] sof_line;
    logic [7:0]       data_line [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_line <= '0;
        end else begin
            vld_line[0] <= vld;
            for (int i = 1; i < DEPTH; i++) begin
                vld_line[i] <= vld_line[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        sof_line[0]  <= sof;
        data_line[0] <= data;
        for (int i = 1; i < DEPTH; i++) begin
            sof_line[i]  <= sof_line[i-1];
            data_line[i] <= data_line[i-1];
        end
    end

    assign vld_dly  = vld_line[DEPTH-1];
    assign sof_dly  = sof_line[DEPTH-1];
    assign data_dly = data_line[DEPTH-1];

endmodule

// File: rtl/rx_segment_router.sv
// Routes each received frame to one output channel chosen by a big-endian segment
// number in its header; frames are held in a delay line until the header is decoded.
module rx_segment_router
    import rx_seg_pkg::*;
#(
    parameter int SEG_OFFSET = 22,
    parameter int SEG_BYTES  = 2,
    parameter int CHANNELS   = 50
) (
    input  logic                rx_clk,
    input  logic                reset,
    input  logic [7:0]          rx_data,
    input  logic                rx_enable,
    output logic [7:0]          out_data,
    output logic [CHANNELS-1:0] out_en,
    output logic                out_sof,
    output logic [7:0]          out_ch,
    output logic                err_range,
    output logic                err_short,
    output logic [15:0]         frame_cnt,
    output logic [15:0]         drop_cnt
);

    localparam int                D           = SEG_OFFSET + SEG_BYTES;
    localparam int                CH_W        = clog2(CHANNELS);
    localparam logic [CNT_W-1:0]  FIELD_FIRST = CNT_W'(SEG_OFFSET);
    localparam logic [CNT_W-1:0]  FIELD_LAST  = CNT_W'(D - 1);
    localparam logic [SEG_W-1:0]  CH_LIMIT    = SEG_W'(CHANNELS);

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    function automatic logic [CHANNELS-1:0] ch_decode(input logic [7:0] ch);
        logic [CHANNELS-1:0] hot;
        hot    = '0;
        hot[0] = 1'b1;
        return hot << ch[CH_W-1:0];
    endfunction

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, idx;
    logic [SEG_W-1:0] seg, seg_nxt, seg_base, seg_shift;
    tag_t             pending, pending_nxt, active, use_tag;
    logic             en_prev, accept, first, take, field_byte;
    logic             rng_hit, short_hit;
    logic             frame_start, route_now;

    logic             vld_p0, sof_p0;
    logic [7:0]       data_p0;
    logic             vld_p1, sof_p1;
    logic [7:0]       data_p1;

    // Header parse: byte index and segment shift for the byte currently on rx_data.
    always_comb begin
        idx      = cnt;
        seg_base = seg;
        if (state == ST_IDLE) begin
            idx      = '0;
            seg_base = '0;
        end
        field_byte = (idx >= FIELD_FIRST) && (idx <= FIELD_LAST);
        seg_shift  = field_byte ? {seg_base[SEG_W-9:0], rx_data} : seg_base;
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        seg_nxt     = seg;
        pending_nxt = pending;
        accept      = 1'b0;
        first       = 1'b0;
        take        = 1'b0;
        rng_hit     = 1'b0;
        short_hit   = 1'b0;

        case (state)
            ST_IDLE: begin
                // Enable already high last cycle means we came out of reset mid-frame.
                if (rx_enable) begin
                    if (en_prev) begin
                        state_nxt = ST_WAIT;
                    end else begin
                        accept = 1'b1;
                        first  = 1'b1;
                        take   = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                if (!rx_enable) begin
                    short_hit   = 1'b1;
                    pending_nxt = TAG_DROP;
                    state_nxt   = ST_IDLE;
                end else begin
                    accept = 1'b1;
                    take   = 1'b1;
                end
            end
            ST_BODY: begin
                if (!rx_enable) state_nxt = ST_IDLE;
                else            accept    = 1'b1;
            end
            ST_WAIT: begin
                if (!rx_enable) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (take) begin
            seg_nxt = seg_shift;
            cnt_nxt = idx + CNT_W'(1);
            if (idx == FIELD_LAST) begin
                state_nxt = ST_BODY;
                if (seg_shift < CH_LIMIT) begin
                    pending_nxt = '{route: 1'b1, ch: seg_shift[7:0]};
                end else begin
                    pending_nxt = TAG_DROP;
                    rng_hit     = 1'b1;
                end
            end else begin
                state_nxt = ST_HDR;
            end
        end
    end

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pending   <= TAG_DROP;
            err_range <= 1'b0;
            err_short <= 1'b0;
            drop_cnt  <= 16'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pending   <= pending_nxt;
            err_range <= rng_hit;
            err_short <= short_hit;
            if (rng_hit || short_hit) drop_cnt <= sat_inc(drop_cnt);
        end
    end

    always_ff @(posedge rx_clk) begin
        seg     <= seg_nxt;
        en_prev <= rx_enable;
    end

    // Stage p0: input register.
    always_ff @(posedge rx_clk) begin
        if (reset) vld_p0 <= 1'b0;
        else       vld_p0 <= accept;
        sof_p0  <= first;
        data_p0 <= rx_data;
    end

    // Stage p1: header-length delay line.
    rx_byte_delay #(
        .DEPTH(D)
    ) u_delay (
        .clk     (rx_clk),
        .reset   (reset),
        .vld     (vld_p0),
        .sof     (sof_p0),
        .data    (data_p0),
        .vld_dly (vld_p1),
        .sof_dly (sof_p1),
        .data_dly(data_p1)
    );

    // Output stage: the tag decided for a frame takes effect as its first byte leaves the line.
    always_comb begin
        frame_start = vld_p1 && sof_p1;
        use_tag     = frame_start ? pending : active;
        route_now   = vld_p1 && use_tag.route;
    end

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            active    <= TAG_DROP;
            out_en    <= '0;
            out_data  <= 8'd0;
            out_sof   <= 1'b0;
            out_ch    <= 8'd0;
            frame_cnt <= 16'd0;
        end else begin
            if (frame_start) active <= pending;
            out_en   <= route_now ? ch_decode(use_tag.ch) : '0;
            out_data <= route_now ? data_p1 : 8'd0;
            out_sof  <= frame_start && pending.route;
            if (frame_start && pending.route) begin
                out_ch    <= pending.ch;
                frame_cnt <= sat_inc(frame_cnt);
            end
        end
    end

endmodule

// File: tb/tb_rx_segment_router.sv
// Directed bench for rx_segment_router: table of single frames plus hand sequences
// for back-to-back frames, mid-frame reset and counter saturation.
module tb_rx_segment_router;

    localparam int CH  = 50;
    localparam int D   = 24;
    localparam int LAT = 26;

    logic          rx_clk    = 1'b0;
    logic          reset     = 1'b1;
    logic [7:0]    rx_data   = 8'd0;
    logic          rx_enable = 1'b0;
    logic [7:0]    out_data;
    logic [CH-1:0] out_en;
    logic          out_sof;
    logic [7:0]    out_ch;
    logic          err_range;
    logic          err_short;
    logic [15:0]   frame_cnt;
    logic [15:0]   drop_cnt;

    rx_segment_router #(
        .SEG_OFFSET(22),
        .SEG_BYTES (2),
        .CHANNELS  (CH)
    ) dut (
        .rx_clk   (rx_clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_enable(rx_enable),
        .out_data (out_data),
        .out_en   (out_en),
        .out_sof  (out_sof),
        .out_ch   (out_ch),
        .err_range(err_range),
        .err_short(err_short),
        .frame_cnt(frame_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    int cyc = 0;
    always @(posedge rx_clk) cyc <= cyc + 1;

    typedef struct {
        int         len;
        logic [7:0] hi;
        logic [7:0] lo;
        bit         route;
        int         ch;
        bit         rng;
        bit         sht;
    } vec_t;

    vec_t       tbl [8];
    logic [7:0] exp_q [$];

    int n_vec = 0;
    int n_fail = 0;
    int now;
    int en_cycles, sof_cnt, sof_cyc, rng_cnt, rng_cyc, sht_cnt, sht_cyc;
    int data_err, idle_nz, hot_err;
    int ch_cnt [256];
    int ch_first [256];
    int ch_last [256];
    int exp_frames, exp_drops;
    int s1, s2;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i, input logic [7:0] hi, input logic [7:0] lo);
        if (i == 22) return hi;
        if (i == 23) return lo;
        return 8'((i * 5 + 3) & 255);
    endfunction

    task automatic clear_stats();
        en_cycles = 0; sof_cnt = 0; sof_cyc = -1; rng_cnt = 0; rng_cyc = -1;
        sht_cnt = 0; sht_cyc = -1; data_err = 0; idle_nz = 0; hot_err = 0;
        for (int k = 0; k < 256; k++) begin
            ch_cnt[k] = 0; ch_first[k] = -1; ch_last[k] = -1;
        end
    endtask

    // Drive one cycle of input after the edge, then sample outputs on the falling edge.
    task automatic tick(input logic en, input logic [7:0] d, input logic rst);
        int hot;
        @(posedge rx_clk);
        #1;
        rx_enable = en;
        rx_data   = d;
        reset     = rst;
        now       = cyc;
        @(negedge rx_clk);
        if (|out_en) begin
            en_cycles++;
            if ($countones(out_en) != 1) hot_err++;
            hot = 0;
            for (int k = 0; k < CH; k++) if (out_en[k]) hot = k;
            ch_cnt[hot]++;
            if (ch_first[hot] < 0) ch_first[hot] = now;
            ch_last[hot] = now;
            if (exp_q.size() == 0) begin
                data_err++;
            end else begin
                if (out_data !== exp_q[0]) data_err++;
                void'(exp_q.pop_front());
            end
        end else if (out_data !== 8'd0) begin
            idle_nz++;
        end
        if (out_sof) begin sof_cnt++; sof_cyc = now; end
        if (err_range) begin rng_cnt++; rng_cyc = now; end
        if (err_short) begin sht_cnt++; sht_cyc = now; end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'd0, 1'b0);
    endtask

    task automatic send_frame(input int len, input logic [7:0] hi, input logic [7:0] lo,
                              input bit route, output int start);
        start = -1;
        if (route) for (int i = 0; i < len; i++) exp_q.push_back(pat(i, hi, lo));
        for (int i = 0; i < len; i++) begin
            tick(1'b1, pat(i, hi, lo), 1'b0);
            if (i == 0) start = now;
        end
    endtask

    initial begin
        tbl[0] = '{len: 64, hi: 8'h00, lo: 8'h07, route: 1, ch: 7,  rng: 0, sht: 0};
        tbl[1] = '{len: 64, hi: 8'h00, lo: 8'h32, route: 0, ch: 0,  rng: 1, sht: 0};
        tbl[2] = '{len: 10, hi: 8'h00, lo: 8'h00, route: 0, ch: 0,  rng: 0, sht: 1};
        tbl[3] = '{len: 24, hi: 8'h00, lo: 8'h31, route: 1, ch: 49, rng: 0, sht: 0};
        tbl[4] = '{len: 23, hi: 8'h00, lo: 8'h01, route: 0, ch: 0,  rng: 0, sht: 1};
        tbl[5] = '{len: 30, hi: 8'h01, lo: 8'h00, route: 0, ch: 0,  rng: 1, sht: 0};
        tbl[6] = '{len: 40, hi: 8'h00, lo: 8'h00, route: 1, ch: 0,  rng: 0, sht: 0};
        tbl[7] = '{len: 25, hi: 8'h00, lo: 8'h2A, route: 1, ch: 42, rng: 0, sht: 0};

        clear_stats();
        exp_frames = 0;
        exp_drops  = 0;

        // Reset state.
        for (int i = 0; i < 4; i++) tick(1'b0, 8'd0, 1'b1);
        check("rst_out_en", $countones(out_en), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_out_sof", int'(out_sof), 0);
        check("rst_out_ch", int'(out_ch), 0);
        check("rst_errs", int'({err_range, err_short}), 0);
        check("rst_frame_cnt", int'(frame_cnt), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
        idle(3);

        // Single-frame table.
        for (int v = 0; v < 8; v++) begin
            clear_stats();
            send_frame(tbl[v].len, tbl[v].hi, tbl[v].lo, tbl[v].route, s1);
            idle(32);
            if (tbl[v].route) exp_frames++;
            if (tbl[v].rng || tbl[v].sht) exp_drops++;
            check($sformatf("v%0d_en_cycles", v), en_cycles, tbl[v].route ? tbl[v].len : 0);
            check($sformatf("v%0d_sof_count", v), sof_cnt, int'(tbl[v].route));
            if (tbl[v].route) begin
                check($sformatf("v%0d_ch_cycles", v), ch_cnt[tbl[v].ch], tbl[v].len);
                check($sformatf("v%0d_first_en_lat", v), ch_first[tbl[v].ch] - s1, LAT);
                check($sformatf("v%0d_sof_lat", v), sof_cyc - s1, LAT);
                check($sformatf("v%0d_out_ch", v), int'(out_ch), tbl[v].ch);
            end
            check($sformatf("v%0d_err_range", v), rng_cnt, int'(tbl[v].rng));
            if (tbl[v].rng) check($sformatf("v%0d_err_range_lat", v), rng_cyc - s1, D);
            check($sformatf("v%0d_err_short", v), sht_cnt, int'(tbl[v].sht));
            if (tbl[v].sht) check($sformatf("v%0d_err_short_lat", v), sht_cyc - s1, tbl[v].len + 1);
            check($sformatf("v%0d_frame_cnt", v), int'(frame_cnt), exp_frames);
            check($sformatf("v%0d_drop_cnt", v), int'(drop_cnt), exp_drops);
            check($sformatf("v%0d_data_err", v), data_err, 0);
            check($sformatf("v%0d_idle_data", v), idle_nz, 0);
            check($sformatf("v%0d_onehot", v), hot_err, 0);
            check($sformatf("v%0d_leftover", v), exp_q.size(), 0);
        end

        // Back-to-back frames with a single idle cycle between them.
        clear_stats();
        send_frame(64, 8'h00, 8'h03, 1'b1, s1);
        idle(1);
        send_frame(64, 8'h00, 8'h04, 1'b1, s2);
        idle(32);
        exp_frames += 2;
        check("b2b_ch3_cycles", ch_cnt[3], 64);
        check("b2b_ch4_cycles", ch_cnt[4], 64);
        check("b2b_ch3_lat", ch_first[3] - s1, LAT);
        check("b2b_ch4_lat", ch_first[4] - s2, LAT);
        check("b2b_no_overlap", int'(ch_last[3] < ch_first[4]), 1);
        check("b2b_sof_count", sof_cnt, 2);
        check("b2b_frame_cnt", int'(frame_cnt), exp_frames);
        check("b2b_data_err", data_err, 0);
        check("b2b_onehot", hot_err, 0);

        // Reset at byte 40 of a 64-byte frame, then a normal frame.
        clear_stats();
        for (int i = 0; i < 15; i++) exp_q.push_back(pat(i, 8'h00, 8'h05));
        s1 = -1;
        for (int i = 0; i < 64; i++) begin
            tick(1'b1, pat(i, 8'h00, 8'h05), (i == 40));
            if (i == 0) s1 = now;
            if (i == 41) begin
                check("mid_rst_out_en", $countones(out_en), 0);
                check("mid_rst_out_data", int'(out_data), 0);
                check("mid_rst_out_ch", int'(out_ch), 0);
                check("mid_rst_frame_cnt", int'(frame_cnt), 0);
            end
        end
        idle(32);
        exp_frames = 0;
        exp_drops  = 0;
        check("mid_rst_en_cycles", en_cycles, 15);
        check("mid_rst_last_en", ch_last[5] - s1, 40);
        check("mid_rst_errs", rng_cnt + sht_cnt, 0);
        check("mid_rst_frame_cnt_end", int'(frame_cnt), 0);
        check("mid_rst_drop_cnt", int'(drop_cnt), 0);
        check("mid_rst_data_err", data_err, 0);
        clear_stats();
        send_frame(30, 8'h00, 8'h09, 1'b1, s2);
        idle(32);
        exp_frames++;
        check("post_rst_ch9_cycles", ch_cnt[9], 30);
        check("post_rst_lat", ch_first[9] - s2, LAT);
        check("post_rst_frame_cnt", int'(frame_cnt), exp_frames);
        check("post_rst_data_err", data_err, 0);

        // Saturation: preload the frame counter just below its ceiling.
        force dut.frame_cnt = 16'hFFFE;
        #2;
        release dut.frame_cnt;
        clear_stats();
        send_frame(24, 8'h00, 8'h01, 1'b1, s1);
        idle(32);
        check("sat_frame_cnt_1", int'(frame_cnt), 65535);
        send_frame(24, 8'h00, 8'h01, 1'b1, s2);
        idle(32);
        check("sat_frame_cnt_2", int'(frame_cnt), 65535);
        check("sat_ch1_cycles", ch_cnt[1], 48);
        check("sat_sof_count", sof_cnt, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_segment_router.md
RX_SEGMENT_ROUTER -- requirements
Module: rx_segment_router

Interface
REQ-001 SHALL have parameter SEG_OFFSET, default 22: byte index (0 = first byte with rx_enable high) of segment-number MSB.
REQ-002 SHALL have parameter SEG_BYTES, default 2, legal 1..4: segment-number field length, big-endian.
REQ-003 SHALL have parameter CHANNELS, default 50, legal 1..256: number of output channels.
REQ-004 SHALL have ports rx_clk in 1 (sole clock) and reset in 1 (synchronous, active-high).
REQ-005 SHALL have ports rx_data in 8 (frame byte) and rx_enable in 1 (frame-valid, high across one frame).
REQ-006 SHALL have ports out_data out 8 and out_en out CHANNELS (one-hot routed byte strobe).
REQ-007 SHALL have ports out_sof out 1 (first byte of routed frame) and out_ch out 8 (channel index of current routed frame).
REQ-008 SHALL have ports err_range out 1 and err_short out 1 (one-cycle drop pulses).
REQ-009 SHALL have ports frame_cnt out 16 and drop_cnt out 16 (saturating counters).

Function
REQ-010 SHALL register rx_data/rx_enable once on input, then delay them through a D = SEG_OFFSET+SEG_BYTES stage line, so that total latency rx_data -> out_data is L = D+2 cycles.
REQ-011 SHALL run FSM IDLE -> HDR on rx_enable rise; HDR -> BODY when field complete; HDR/BODY -> IDLE on rx_enable fall; any state -> WAIT on reset release with rx_enable high; WAIT -> IDLE on rx_enable low.
REQ-012 SHALL count bytes in HDR with a 12-bit counter and shift bytes SEG_OFFSET..D-1 into a 32-bit segment register.
REQ-013 SHALL, on field completion, write a pending tag {route, channel}: route=1 if value < CHANNELS, else route=0 with err_range pulse same cycle.
REQ-014 SHALL, on rx_enable fall in HDR (frame shorter than D bytes), write pending tag route=0 and pulse err_short.
REQ-015 SHALL copy the pending tag into the active tag when the delayed start-of-frame byte exits the line, so back-to-back frames separated by one idle cycle are tagged independently.
REQ-016 SHALL drive out_en[out_ch]=1 with out_data for every byte of a routed frame, including header bytes 0..D-1, and all out_en=0 for dropped frames and idle cycles.
REQ-017 SHALL pulse out_sof with first routed byte; out_ch holds its value until the next out_sof.
REQ-018 SHALL increment frame_cnt on each out_sof and drop_cnt on each err_range/err_short; both saturate at 16'hFFFF.
REQ-019 SHALL drive out_data = 0 whenever all out_en are 0.
REQ-020 SHALL ignore bytes arriving in WAIT (no tag, no counters, no output).

Reset
REQ-021 SHALL, on reset, set out_en=0, out_data=0, out_sof=0, out_ch=0, err_range=0, err_short=0, frame_cnt=0, drop_cnt=0, FSM=IDLE, delay line valid bits=0, tags=drop.
REQ-022 SHALL discard any frame partly in flight at reset; no partial frame is emitted after reset deasserts.

Structure
REQ-023 SHALL place FSM state encoding, tag field layout, and a clog2 constant function in shared package rx_seg_pkg.
REQ-024 SHALL implement the delay line as sub-module rx_byte_delay (parameter DEPTH, carries {valid, sof, data[7:0]}, synchronous reset clears valid).
REQ-025 SHALL contain no per-channel state; CHANNELS affects only decode width.

Verification
REQ-026 SHALL cover: 64-byte frame, bytes 22/23 = 00/07 -> out_en[7] high 64 cycles starting 26 cycles after first byte, out_sof once, out_ch=7, frame_cnt=1.
REQ-027 SHALL cover: segment 00/32 (50) with CHANNELS=50 -> no out_en, err_range one pulse 24 cycles after first byte, drop_cnt=1.
REQ-028 SHALL cover: 10-byte frame -> err_short pulse at fall, no output, drop_cnt=1.
REQ-029 SHALL cover: frames seg 3 then seg 4, 1 idle cycle between -> out_en[3] then out_en[4], each exactly its frame length, no overlap, frame_cnt=2.
REQ-030 SHALL cover: reset asserted at byte 40 of a 64-byte frame -> no out_en after reset, remaining 23 bytes ignored (WAIT), next frame routed normally.
REQ-031 SHALL cover: frame_cnt preloaded by 65535 routed frames -> remains 16'hFFFF on the next frame.
